lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store unit that is the initiating side of the data memory port. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the 64-bit big-endian doubleword memory interface (`MemRead`/`MemWrite`, combinational read, synchronous write). It supports byte, half, word and double accesses, using read-modify-write for sub-doubleword stores, and returns sign- or zero-extended load data over a valid/ready response channel.

## Interface
- `MEM_BYTES`, 1024: size of the data memory; an address `>= MEM_BYTES` faults.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified (low N bytes used).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 64: extended load data; 0 for stores and faults.
- `resp_fault` out 1: misaligned or out-of-range request.
- `mem_address` out 64: memory address.
- `mem_write_data` out 64: memory write data.
- `mem_read` out 1: `MemRead` strobe.
- `mem_write` out 1: `MemWrite` strobe.
- `mem_read_data` in 64: combinational memory read data; bytes `mem[A..A+7]`, with `mem[A]` in bits [63:56].

## Operation
- States: `IDLE`, `LOAD`, `ST_RD`, `ST_WR`, `RESP`.
- `req_ready` = (state == `IDLE`). The unit latches the request on `req_valid && req_ready`.
- Fault check at accept:
  - Misaligned: `addr % N != 0`, with N = 1, 2, 4, 8 bytes.
  - Out of range: `addr >= MEM_BYTES`.
  - On fault: go to `RESP` with `resp_fault`=1 and `resp_rdata`=0. No memory strobe is ever asserted.
- Load: `IDLE` → `LOAD`.
  - `LOAD` asserts `mem_read`; `mem_address` = latched address.
  - Captures `mem_read_data[63:64-8N]`, right-justifies it, and extends it to 64 bits per `req_unsigned`.
  - Then → `RESP`.
- Store with N = 8: `IDLE` → `ST_WR` directly; `mem_write_data` = `req_wdata`.
- Store with N < 8: `IDLE` → `ST_RD` → `ST_WR`.
  - `ST_RD` asserts `mem_read` and captures a merge value: top N bytes = `req_wdata[8N-1:0]`, remaining bytes = `mem_read_data` unchanged.
  - `ST_WR` asserts `mem_write` with the merged value at the same address.
- `ST_WR` → `RESP`.
- `RESP` holds `resp_valid`=1 with stable `resp_rdata`/`resp_fault` until `resp_ready`=1, then → `IDLE`.
- Address wrap: a sub-doubleword access near the top of memory reads and writes back 8 bytes whose tail wraps to address 0. Wrapped bytes are rewritten with their unchanged values, which is legal.
- `mem_read` and `mem_write` are never asserted together. Both are 0 outside `LOAD`/`ST_RD`/`ST_WR`.

## Timing
- Request accepted in cycle T.
- Load: `mem_read` in T+1; `resp_valid` from T+2.
- Store D: `mem_write` in T+1 (memory updates at the T+1→T+2 edge); `resp_valid` from T+2.
- Store B/H/W: `mem_read` in T+1, `mem_write` in T+2; `resp_valid` from T+3.
- Fault: `resp_valid` from T+1.
- Minimum request-to-request spacing: response handshake cycle + 1. No new request is accepted while in `RESP`.
- All memory outputs are decoded from registered state and latched fields; they are glitch-free within a cycle.
- Reset values:
  - State = `IDLE`; `req_ready`=1.
  - `resp_valid`, `resp_fault`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_address`, `mem_write_data` = 0.
- Reset mid-operation: state is forced to `IDLE` immediately and strobes drop asynchronously. A store in `ST_RD` leaves memory untouched. A store in `ST_WR` commits only if `reset` is high at that rising edge. No response is produced for an aborted request.

## Structure
- Shared package `lsu_pkg` holds:
  - `mem_size_t` (B/H/W/D) and `lsu_state_t`.
  - `SIZE_BYTES` constants and the big-endian lane convention.
- One combinational sub-module, `lsu_be_lane`, is natural:
  - Inputs: size, unsigned flag, 64-bit memory word, 64-bit store data.
  - Outputs: extended load value and merged store word.
  - Shared by `LOAD` and `ST_RD`.

## Test plan
All scenarios start from a zeroed memory.

1. sd `0x0102030405060708` @0x10, then ld @0x10 → `resp_rdata`=`0x0102030405060708`. Store response at T+2, load response at T+2.
2. After scenario 1: lb signed @0x11 → `0x02`; lw @0x14 → `0x05060708`; lh unsigned @0x16 → `0x0708`.
3. After scenario 1: sb `0xAA` @0x13, then ld @0x10 → `0x010203AA05060708`. lb signed @0x13 → `0xFFFFFFFFFFFFFFAA`; lbu @0x13 → `0xAA`.
4. lh @0x11 and sw @0x3FC+0x400 → each gives `resp_fault`=1 and `resp_rdata`=0 at T+1; `mem_read`/`mem_write` stay 0 throughout.
5. Load with `resp_ready` held low for 3 cycles → `resp_valid` and `resp_rdata` stable, `req_ready`=0, and a new `req_valid` is ignored until the handshake completes.
6. sh `0xBEEF` @0x20 with `reset` pulsed low during `ST_RD` → no `mem_write`, all outputs at reset values, `req_ready`=1 after release, and ld @0x20 → 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its memory port.
package lsu_pkg;

    // Default data memory size in bytes; the top module exposes it as a parameter.
    localparam int unsigned DEFAULT_MEM_BYTES = 1024;

    // Access size encoding as it appears on the request channel.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    // Control states of the unit.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // Bytes moved per access size.
    localparam int unsigned SIZE_BYTES_B = 1;
    localparam int unsigned SIZE_BYTES_H = 2;
    localparam int unsigned SIZE_BYTES_W = 4;
    localparam int unsigned SIZE_BYTES_D = 8;

    // Big-endian lane convention: the byte at the access address occupies
    // bits [63:56] of the memory word, so an N-byte access always uses the
    // top N bytes of the doubleword returned for that address.
    localparam int unsigned WORD_BYTES = 8;

    // Mask of address bits that must be zero for a naturally aligned access.
    function automatic logic [63:0] align_mask(input mem_size_t size);
        logic [63:0] mask;
        case (size)
            SZ_B:    mask = 64'(SIZE_BYTES_B - 1);
            SZ_H:    mask = 64'(SIZE_BYTES_H - 1);
            SZ_W:    mask = 64'(SIZE_BYTES_W - 1);
            default: mask = 64'(SIZE_BYTES_D - 1);
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response channel between execute and the LSU, and the LSU-driven
// data memory bus.
interface lsu_req_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;

    // Execute stage side: issues requests, consumes responses.
    modport master (
        output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    // LSU side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

interface mem_bus_if;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;

    // Initiator (the LSU).
    modport master (
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_read_data
    );

    // Data memory.
    modport slave (
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_be_lane.sv
// Big-endian lane steering: extracts and extends load data from the top N
// bytes of a memory doubleword, and builds the read-modify-write store word.
module lsu_be_lane
    import lsu_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [63:0] mem_word,
    input  logic [63:0] store_data,
    output logic [63:0] load_value,
    output logic [63:0] merge_word
);

    // Lane select and extension for both load return and store merge.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        load_value = '0;
        merge_word = mem_word;
        case (size)
            SZ_B: begin
                load_value = is_unsigned ? {56'd0, mem_word[63:56]}
                                         : {{56{mem_word[63]}}, mem_word[63:56]};
                merge_word = {store_data[7:0], mem_word[55:0]};
            end
            SZ_H: begin
                load_value = is_unsigned ? {48'd0, mem_word[63:48]}
                                         : {{48{mem_word[63]}}, mem_word[63:48]};
                merge_word = {store_data[15:0], mem_word[47:0]};
            end
            SZ_W: begin
                load_value = is_unsigned ? {32'd0, mem_word[63:32]}
                                         : {{32{mem_word[63]}}, mem_word[63:32]};
                merge_word = {store_data[31:0], mem_word[31:0]};
            end
            SZ_D: begin
                load_value = mem_word;
                merge_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a 64-bit big-endian doubleword data memory.
// One request in flight; sub-doubleword stores use read-modify-write.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    lsu_req_if.slave   req_bus,
    mem_bus_if.master  mem_bus
);

    lsu_state_t  state;
    lsu_state_t  next_state;
    mem_size_t   size_q;
    logic        unsigned_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        fault_q;

    logic        accept;
    logic        fault_now;
    logic [63:0] load_value;
    logic [63:0] merge_word;

    assign accept    = req_bus.req_valid && (state == IDLE);
    assign fault_now = ((req_bus.req_addr & align_mask(req_bus.req_size)) != 64'd0)
                    || (req_bus.req_addr >= 64'(MEM_BYTES));

    lsu_be_lane u_lane (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .mem_word    (mem_bus.mem_read_data),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .merge_word  (merge_word)
    );

    // State register; reset forces IDLE at once, dropping all strobes.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is assigned non-blocking so every flop samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode from the current state and request/response handshakes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault_now)                    next_state = RESP;
                    else if (!req_bus.req_is_store)   next_state = LOAD;
                    else if (req_bus.req_size == SZ_D) next_state = ST_WR;
                    else                              next_state = ST_RD;
                end
            end
            LOAD:    next_state = RESP;
            ST_RD:   next_state = ST_WR;
            ST_WR:   next_state = RESP;
            RESP:    if (req_bus.resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latched request fields, captured load result and merged store word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (accept) begin
                size_q     <= req_bus.req_size;
                unsigned_q <= req_bus.req_unsigned;
                addr_q     <= req_bus.req_addr;
                wdata_q    <= req_bus.req_wdata;
                rdata_q    <= '0;
                fault_q    <= fault_now;
            end
            if (state == LOAD)  rdata_q <= load_value;
            if (state == ST_RD) wdata_q <= merge_word;
        end
    end

    // All outputs come straight from registered state and latched fields.
    assign req_bus.req_ready      = (state == IDLE);
    assign req_bus.resp_valid     = (state == RESP);
    assign req_bus.resp_rdata     = rdata_q;
    assign req_bus.resp_fault     = fault_q;
    assign mem_bus.mem_address    = addr_q;
    assign mem_bus.mem_write_data = wdata_q;
    assign mem_bus.mem_read       = (state == LOAD) || (state == ST_RD);
    assign mem_bus.mem_write      = (state == ST_WR);

endmodule
